// File: rtl/screen_pkg.sv
// Shared types for the TicTacToe screen sequencer:
// state encodings, winner codes and the screen-enable bundle.
package screen_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_WIN   = 2'b10
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;

  typedef struct packed {
    logic ss;
    logic ps;
    logic ws;
  } ce_t;

  typedef struct packed {
    logic   vld;
    state_t tgt;
  } req_t;

  function automatic ce_t ce_of(state_t s);
    ce_t c;
    c = '0;
    unique case (1'b1)
      (s == ST_PLAY): c.ps = 1'b1;
      (s == ST_WIN):  c.ws = 1'b1;
      default:        c.ss = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/screen_sequencer_button.sv
// Start-button conditioning: 2-FF synchronizer, stability
// counter and a one-cycle pulse on the debounced rising edge.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn,
  output logic start_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_q;

  // cnt counts consecutive samples that disagree with level
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync        <= '0;
      cnt         <= '0;
      level       <= 1'b0;
      level_q     <= 1'b0;
      start_press <= 1'b0;
    end else begin
      sync        <= {sync[0], btn};
      level_q     <= level;
      start_press <= level & ~level_q;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Frame-synchronous screen sequencer: START / PLAY / WIN, with
// every screen change committed on the vsync falling edge.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned WIN_HOLD_FRAMES = 300
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start_btn,
  input  logic       game_over,
  input  logic [1:0] winner,
  output logic       ceSS,
  output logic       cePS,
  output logic       ceWS,
  output logic [1:0] winner_code,
  output logic       game_reset,
  output logic [1:0] state
);

  localparam int unsigned FW = $clog2(WIN_HOLD_FRAMES + 1);
  localparam logic [FW-1:0] HOLD_LAST = FW'(WIN_HOLD_FRAMES - 1);
  localparam logic [FW-1:0] HOLD_MAX  = FW'(WIN_HOLD_FRAMES);

  logic          start_press;
  logic          vsync_q;
  logic          frame_edge;
  logic          commit;
  state_t        st_q, st_d;
  req_t          req_q, req_d, req_n;
  logic [FW-1:0] frm_q, frm_d;
  logic [1:0]    wcode_d;
  ce_t           ce_q, ce_d;
  logic          gr_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .btn        (start_btn),
    .start_press(start_press)
  );

  always_ff @(posedge clk_100MHz) begin
    vsync_q <= vsync;
  end

  assign frame_edge = vsync_q & ~vsync;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      st_q        <= ST_START;
      req_q       <= '0;
      frm_q       <= '0;
      winner_code <= WIN_NONE;
      ce_q        <= ce_of(ST_START);
      game_reset  <= 1'b0;
    end else begin
      st_q        <= st_d;
      req_q       <= req_d;
      frm_q       <= frm_d;
      winner_code <= wcode_d;
      ce_q        <= ce_d;
      game_reset  <= gr_d;
    end
  end

  always_comb begin
    req_n   = req_q;
    wcode_d = winner_code;
    frm_d   = frm_q;
    unique case (st_q)
      ST_START: begin
        if (start_press) begin
          req_n = '{vld: 1'b1, tgt: ST_PLAY};
        end
      end
      ST_PLAY: begin
        if (game_over && !req_q.vld) begin
          req_n   = '{vld: 1'b1, tgt: ST_WIN};
          wcode_d = winner;
        end
      end
      ST_WIN: begin
        if (frame_edge && frm_q != HOLD_MAX) begin
          frm_d = frm_q + 1'b1;
        end
        // a pending or same-edge rematch outranks the timeout
        if (start_press) begin
          req_n = '{vld: 1'b1, tgt: ST_PLAY};
        end else if (frame_edge && !req_q.vld &&
                     frm_q >= HOLD_LAST) begin
          req_n = '{vld: 1'b1, tgt: ST_START};
        end
      end
      default: req_n = '0;
    endcase

    commit = frame_edge & req_n.vld;
    st_d   = commit ? req_n.tgt : st_q;
    req_d  = commit ? '0 : req_n;
    if (commit && req_n.tgt == ST_WIN) begin
      frm_d = '0;
    end
  end

  always_comb begin
    ce_d = ce_of(st_d);
    gr_d = commit && (req_n.tgt == ST_PLAY);
  end

  assign ceSS  = ce_q.ss;
  assign cePS  = ce_q.ps;
  assign ceWS  = ce_q.ws;
  assign state = st_q;

endmodule
